// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH:MM:SS driver: a prescaler steps a digit index,
// time is snapshotted once per frame, and an/seg are registered, active-low.
module time_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame_sync
);

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [5:0]    AN_OFF    = 6'b111111;
    localparam logic [6:0]    SEG_OFF   = 7'b1111111;
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_sync_q, frame_sync_d;

    logic          tick;
    logic          wrap;
    logic          blank;

    function automatic logic [6:0] seg_of(input logic [5:0] d);
        logic [6:0] code;
        case (d)
            6'd0:    code = 7'b1000000;
            6'd1:    code = 7'b1111001;
            6'd2:    code = 7'b0100100;
            6'd3:    code = 7'b0110000;
            6'd4:    code = 7'b0011001;
            6'd5:    code = 7'b0010010;
            6'd6:    code = 7'b0000010;
            6'd7:    code = 7'b1111000;
            6'd8:    code = 7'b0000000;
            6'd9:    code = 7'b0010000;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

    // Field 0 = seconds, 1 = minutes, 2 = hours; all decoding reads the shadow copy only.
    logic [5:0] field_val [3];
    assign field_val[0] = sec_q;
    assign field_val[1] = min_q;
    assign field_val[2] = {1'b0, hr_q};

    logic [6:0] digit_seg [6];

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        localparam int         FIELD = gi / 2;
        localparam logic [5:0] LIMIT = (FIELD == 2) ? 6'd23 : 6'd59;
        logic [5:0] digit;
        if (gi % 2 == 1) begin : g_tens
            assign digit = field_val[FIELD] / 6'd10;
        end else begin : g_ones
            assign digit = field_val[FIELD] % 6'd10;
        end
        // An out-of-range field shows dashes on both of its digits.
        assign digit_seg[gi] = (field_val[FIELD] > LIMIT) ? SEG_DASH : seg_of(digit);
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank = 1'b0;
    end else begin : g_blank
        assign blank = (pcnt_q < PW'(BLANK_CYCLES));
    end

    always_comb begin
        tick         = (pcnt_q == PCNT_LAST);
        wrap         = tick && (idx_q == 3'd5);
        pcnt_d       = tick ? '0 : pcnt_q + PW'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end
        sec_d        = wrap ? seconds : sec_q;
        min_d        = wrap ? minutes : min_q;
        hr_d         = wrap ? hours   : hr_q;
        frame_sync_d = wrap;
        an_d         = blank ? AN_OFF : ~(6'd1 << idx_q);
        seg_d        = SEG_OFF;
        case (idx_q)
            3'd0:    seg_d = digit_seg[0];
            3'd1:    seg_d = digit_seg[1];
            3'd2:    seg_d = digit_seg[2];
            3'd3:    seg_d = digit_seg[3];
            3'd4:    seg_d = digit_seg[4];
            3'd5:    seg_d = digit_seg[5];
            default: seg_d = SEG_OFF;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q       <= '0;
            idx_q        <= 3'd0;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hr_q         <= 5'd0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_sync_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hr_q         <= hr_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Randomised bench for time_display_scan: outputs are predicted each cycle from
// elapsed-cycle arithmetic and a per-frame time snapshot.
module tb_time_display_scan;

    localparam int SD    = 4;
    localparam int BL    = 1;
    localparam int FRAME = 6 * SD;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [5:0] an, an0;
    logic [6:0] seg, seg0;
    logic       frame_sync, frame_sync0;

    always #5 Clk = ~Clk;

    time_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .Clk(Clk), .reset_n(reset_n), .seconds(seconds), .minutes(minutes), .hours(hours),
        .an(an), .seg(seg), .frame_sync(frame_sync)
    );

    time_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(0)) dut_noblank (
        .Clk(Clk), .reset_n(reset_n), .seconds(seconds), .minutes(minutes), .hours(hours),
        .an(an0), .seg(seg0), .frame_sync(frame_sync0)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_fs = 0;
    int pulses = 0;
    logic [5:0] m_sec = 6'd0, m_min = 6'd0;
    logic [4:0] m_hr = 5'd0;
    logic [6:0] seg_tab [10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx);
        int v;
        int lim;
        case (idx / 2)
            0:       begin v = int'(m_sec); lim = 59; end
            1:       begin v = int'(m_min); lim = 59; end
            default: begin v = int'(m_hr);  lim = 23; end
        endcase
        if (v > lim) return 7'b0111111;
        return seg_tab[(idx % 2 == 1) ? v / 10 : v % 10];
    endfunction

    // One clock edge: predict from the cycle number, then compare 1 time unit later.
    task automatic step();
        int c, idx, pc;
        logic [5:0] ea, ea0;
        logic [6:0] es;
        logic ef;
        @(posedge Clk);
        c   = n;
        n++;
        pc  = c % SD;
        idx = (c / SD) % 6;
        ea0 = ~(6'd1 << idx);
        ea  = (pc < BL) ? 6'h3f : ea0;
        es  = exp_seg(idx);
        ef  = (n % FRAME == 0);
        if (ef) begin
            m_sec = seconds;
            m_min = minutes;
            m_hr  = hours;
        end
        #1;
        check_eq("an", an, ea);
        check_eq("seg", seg, es);
        check_eq("frame_sync", frame_sync, ef);
        check_eq("an_noblank", an0, ea0);
        check_eq("seg_noblank", seg0, es);
        if (frame_sync) begin
            pulses++;
            check_eq("fs_gap", n - last_fs, FRAME);
            last_fs = n;
            $display("frame at edge %0d: snapshot %0d:%0d:%0d", n, m_hr, m_min, m_sec);
        end
    endtask

    task automatic apply_reset(input int hold);
        reset_n = 1'b0;
        repeat (hold) @(posedge Clk);
        #1;
        check_eq("rst_an", an, 6'h3f);
        check_eq("rst_seg", seg, 7'h7f);
        check_eq("rst_fs", frame_sync, 1'b0);
        check_eq("rst_an_noblank", an0, 6'h3f);
        @(negedge Clk);
        reset_n = 1'b1;
        n       = 0;
        last_fs = 0;
        m_sec   = 6'd0;
        m_min   = 6'd0;
        m_hr    = 5'd0;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        reset_n = 1'b0;
        seconds = 6'd56;
        minutes = 6'd34;
        hours   = 5'd12;
        apply_reset(2);

        // 12:34:56, then seconds 56 -> 57 partway into frame 2.
        repeat (FRAME + 10) step();
        seconds = 6'd57;
        repeat (2 * FRAME - 10) step();

        // Out-of-range hours and minutes.
        hours   = 5'd25;
        minutes = 6'd60;
        seconds = 6'd59;
        repeat (2 * FRAME) step();

        // Asynchronous reset while digit 3 is being scanned.
        while ((n / SD) % 6 != 3) step();
        #1 reset_n = 1'b0;
        #1;
        check_eq("async_an", an, 6'h3f);
        check_eq("async_seg", seg, 7'h7f);
        check_eq("async_fs", frame_sync, 1'b0);
        hours   = 5'd23;
        minutes = 6'd59;
        seconds = 6'd59;
        apply_reset(1);

        pulses = 0;
        repeat (3 * FRAME) step();
        check_eq("fs_count", pulses, 3);

        repeat (40 * FRAME) begin
            if ($urandom_range(0, 7) == 0) begin
                seconds = 6'($urandom_range(0, 61));
                minutes = 6'($urandom_range(0, 61));
                hours   = 5'($urandom_range(0, 25));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_CYCLES, default 500: cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.
REQ-003 Clk  input  1  system clock; every register in the block updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 seconds  input  6  binary seconds from the time counter; legal range 0..59.
REQ-006 minutes  input  6  binary minutes; legal range 0..59.
REQ-007 hours  input  5  binary hours; legal range 0..23.
REQ-008 an  output  6  digit enables, active-low, registered; an[i] drives digit i.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 frame_sync  output  1  one-cycle pulse, registered; asserts when a new time snapshot is taken.

Function
REQ-011 Prescaler pcnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (pcnt == SCAN_DIV-1).
REQ-012 Digit index idx (0..5) SHALL increment on each tick and wrap from 5 to 0.
REQ-013 On the tick where idx wraps 5->0, the block SHALL latch seconds, minutes and hours into shadow registers; all display data comes only from the shadow registers (no tearing).
REQ-014 frame_sync SHALL be high for exactly the one cycle after the snapshot edge; it is otherwise low.
REQ-015 Digit mapping: idx0 = seconds ones, idx1 = seconds tens, idx2 = minutes ones, idx3 = minutes tens, idx4 = hours ones, idx5 = hours tens.
REQ-016 Tens = value/10 and ones = value%10, computed on the shadow value; no leading-zero blanking ("00" displays as two zeros).
REQ-017 Segment encoding SHALL be the standard active-low 7-segment code for 0-9 (for example 0 = 7'b1000000, 8 = 7'b0000000).
REQ-018 If the shadow seconds or minutes value is > 59, or the shadow hours value is > 23, both digits of that field SHALL show a dash (seg = 7'b0111111).
REQ-019 an and seg SHALL be registered with one-cycle latency from the (idx, pcnt) state that selects them.
REQ-020 While pcnt < BLANK_CYCLES, an SHALL be 6'b111111; otherwise an SHALL be one-hot-low at bit idx.
REQ-021 seg SHALL follow idx regardless of blanking.
REQ-022 Input changes between snapshots SHALL have no effect on an, seg or frame_sync.

Reset
REQ-023 While reset_n = 0: pcnt = 0, idx = 0, shadow registers = 0, an = 6'b111111, seg = 7'b1111111, frame_sync = 0.
REQ-024 After reset release, the first frame SHALL display 00:00:00; the first snapshot occurs on the first 5->0 wrap, at 6*SCAN_DIV cycles after release.
REQ-025 Reset asserted mid-slot or mid-frame SHALL force the REQ-023 values immediately (asynchronously); no partial frame resumes.

Verification (SCAN_DIV=4, BLANK_CYCLES=1 unless stated)
REQ-026 Reset, then inputs 12:34:56 held -> frame 1 shows 000000; frame_sync pulses once at cycle 24. Frame 2 per-digit seg reads 6,5,4,3,2,1 in idx 0..5.
REQ-027 Blanking -> in every slot, an = 6'b111111 for one cycle, then for 3 cycles bit idx is low and all other bits are high; with BLANK_CYCLES=0, an is never all-ones after reset.
REQ-028 Change seconds from 56 to 57 mid-frame -> displayed digits unchanged until the next frame_sync; the following frame shows 7 on idx0.
REQ-029 hours = 25, minutes = 60, seconds = 59 -> idx2..5 show 7'b0111111; idx0 shows 9 and idx1 shows 5.
REQ-030 Assert reset_n low for 1 cycle during idx = 3 -> an = 6'b111111 and seg = 7'b1111111 with no clock edge; restart at idx 0 with shadow = 0.
REQ-031 Run 3 frames with inputs 23:59:59 -> exactly 3 frame_sync pulses, spaced 24 cycles apart.
